phrase_composer: RTL

Parametrised successor to the LCD phrase bank. Streams one ASCII character per display address by overlaying N live decimal fields and an R/W flag onto a template character supplied by the external template ROM. Binary field values are snapshotted on request and converted to BCD by a serial double-dabble engine. The result is committed atomically, so the display never shows a half-converted field. Sits between the LCD write sequencer (which supplies disp_addr) and the template ROM.

---
 rtl/phrase_pkg.sv | 29 ++
 rtl/bin2bcd_serial.sv | 43 ++++
 rtl/phrase_composer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/phrase_pkg.sv
// Shared constants, FSM state encoding and BCD helper functions for the
// phrase composer and its serial binary-to-BCD engine.
package phrase_pkg;

  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_HASH  = 8'h23;
  localparam logic [7:0] CH_R     = 8'h52;
  localparam logic [7:0] CH_W     = 8'h57;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  // Nibble count needed to hold any VALUE_W-bit binary value plus one spare
  // digit: ceil(value_w*log10(2) + 1), using log10(2) ~= 0.30103.
  function automatic int bcd_nibbles(input int value_w);
    return (value_w * 30103 + 199999) / 100000;
  endfunction

  // Double-dabble correction applied to each nibble before every shift.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: one binary bit enters the BCD register per
// shift. bcd_shifted is the value the BCD register takes on the next shift,
// so the caller can capture the final result on the last shift edge.
module bin2bcd_serial
  import phrase_pkg::*;
#(
  parameter int VALUE_W = 8,
  parameter int BCD_W   = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load,
  input  logic               shift,
  input  logic [VALUE_W-1:0] value,
  output logic [BCD_W-1:0]   bcd_shifted
);

  logic [VALUE_W-1:0] bin_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   adj;

  // Adjust every nibble, then shift the next binary MSB into the BCD LSB.
  always_comb begin
    adj = '0;
    for (int i = 0; i < BCD_W / 4; i++) adj[4*i +: 4] = add3(bcd_q[4*i +: 4]);
    bcd_shifted = {adj[BCD_W-2:0], bin_q[VALUE_W-1]};
  end

  // Shifter and BCD accumulator.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bin_q <= '0;
      bcd_q <= '0;
    end else if (load) begin
      bin_q <= value;
      bcd_q <= '0;
    end else if (shift) begin
      bin_q <= bin_q << 1;
      bcd_q <= bcd_shifted;
    end
  end

endmodule

// File: rtl/phrase_composer.sv
// Composes one LCD character per display address by overlaying NUM_FIELDS
// decimal fields and an R/W flag on the template ROM character. Field values
// are snapshotted and converted serially; all digits are committed at once.
// Build option: define PHRASE_BLANK_LEADING_EN to show leading zeros as
// spaces (least-significant digit always shown).
//
// state  | meaning
// IDLE   | waiting for update
// LOAD   | load snapshot field k into the converter
// SHIFT  | VALUE_W double-dabble shifts for field k
// COMMIT | copy all scratch BCD to the displayed registers
module phrase_composer
  import phrase_pkg::*;
#(
  parameter int NUM_FIELDS = 3,
  parameter int VALUE_W    = 8,
  parameter int DIGITS     = 3,
  parameter int ADDR_W     = 5,
  parameter logic [NUM_FIELDS*ADDR_W-1:0] FIELD_POS = {5'd29, 5'd20, 5'd4},
  parameter int RW_POS     = 14
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          update,
  input  logic [NUM_FIELDS*VALUE_W-1:0] field_values,
  input  logic                          rw_in,
  input  logic [ADDR_W-1:0]             disp_addr,
  input  logic [7:0]                    template_char,
  output logic [7:0]                    char_out,
  output logic                          busy,
  output logic                          done
);

  localparam int BCD_N = bcd_nibbles(VALUE_W);
  localparam int BCD_W = 4 * BCD_N;
  localparam int KW    = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int CW    = $clog2(VALUE_W + 1);

  state_t state, state_nxt;
  logic [NUM_FIELDS*VALUE_W-1:0] snap;
  logic [BCD_W-1:0] scratch   [NUM_FIELDS];
  logic [BCD_W-1:0] committed [NUM_FIELDS];
  logic [KW-1:0]    k;
  logic [CW-1:0]    cnt;
  logic             pending;
  logic             restart;
  logic             take_snap;
  logic             last_field;
  logic             eng_load;
  logic             eng_shift;
  logic [BCD_W-1:0] eng_bcd;

  assign last_field = (k == KW'(NUM_FIELDS - 1));
  // A request seen during the conversion (or at the commit edge itself)
  // chains straight into a fresh conversion without passing through IDLE.
  assign restart    = (state == COMMIT) && (pending || update);

  bin2bcd_serial #(
    .VALUE_W (VALUE_W),
    .BCD_W   (BCD_W)
  ) u_bcd (
    .clock       (clock),
    .reset_n     (reset_n),
    .load        (eng_load),
    .shift       (eng_shift),
    .value       (snap[int'(k)*VALUE_W +: VALUE_W]),
    .bcd_shifted (eng_bcd)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (update) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (cnt == '0) state_nxt = last_field ? COMMIT : LOAD;
      COMMIT:  state_nxt = restart ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM-decoded controls.
  always_comb begin
    busy      = (state != IDLE);
    eng_load  = (state == LOAD);
    eng_shift = (state == SHIFT);
    take_snap = ((state == IDLE) && update) || restart;
  end

  // Snapshot, field index, shift down-counter, scratch/committed BCD, done.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      snap    <= '0;
      k       <= '0;
      cnt     <= '0;
      pending <= 1'b0;
      done    <= 1'b0;
      for (int f = 0; f < NUM_FIELDS; f++) begin
        scratch[f]   <= '0;
        committed[f] <= '0;
      end
    end else begin
      done <= (state == COMMIT);
      if (take_snap) begin
        snap <= field_values;
        k    <= '0;
      end
      if (state == COMMIT)       pending <= 1'b0;
      else if (busy && update)   pending <= 1'b1;
      if (state == LOAD) cnt <= CW'(VALUE_W - 1);
      if (state == SHIFT) begin
        cnt <= cnt - 1'b1;
        if (cnt == '0) begin
          scratch[k] <= eng_bcd;
          if (!last_field) k <= k + 1'b1;
        end
      end
      if (state == COMMIT) begin
        for (int f = 0; f < NUM_FIELDS; f++) committed[f] <= scratch[f];
      end
    end
  end

  logic [7:0]  ch_nxt;
  logic        hit;
  logic        ovf;
  logic [31:0] off;
  int          nib;
  logic [3:0]  digit;
`ifdef PHRASE_BLANK_LEADING_EN
  logic        lead_nz;
`endif

  // Character select: R/W flag, then lowest-index matching field, else template.
  always_comb begin
    ch_nxt = template_char;
    hit    = 1'b0;
    ovf    = 1'b0;
    off    = '0;
    nib    = 0;
    digit  = '0;
`ifdef PHRASE_BLANK_LEADING_EN
    lead_nz = 1'b0;
`endif
    if (disp_addr == ADDR_W'(RW_POS)) begin
      ch_nxt = rw_in ? CH_W : CH_R;
    end else begin
      for (int f = 0; f < NUM_FIELDS; f++) begin
        off = 32'(disp_addr) - 32'(FIELD_POS[f*ADDR_W +: ADDR_W]);
        if (!hit && (off < 32'(DIGITS))) begin
          hit = 1'b1;
          nib = DIGITS - 1 - int'(off);
          ovf = 1'b0;
          for (int n = DIGITS; n < BCD_N; n++) ovf = ovf | (committed[f][4*n +: 4] != 4'd0);
          digit = committed[f][4*nib +: 4];
`ifdef PHRASE_BLANK_LEADING_EN
          lead_nz = 1'b0;
          for (int n = 0; n < DIGITS; n++) begin
            if ((n >= nib) && (committed[f][4*n +: 4] != 4'd0)) lead_nz = 1'b1;
          end
          if (ovf)                          ch_nxt = CH_HASH;
          else if ((nib != 0) && !lead_nz)  ch_nxt = CH_SPACE;
          else                              ch_nxt = CH_ZERO + {4'd0, digit};
`else
          if (ovf) ch_nxt = CH_HASH;
          else     ch_nxt = CH_ZERO + {4'd0, digit};
`endif
        end
      end
    end
  end

  // Registered character output.
  always_ff @(posedge clock) begin
    if (!reset_n) char_out <= CH_SPACE;
    else          char_out <= ch_nxt;
  end

endmodule
